// File: rtl/io_vector_table_slave_if.sv
// IO_Interface task channel between a memory-bus master and a responder.
// The master holds a request until it sees the one-cycle taskReady pulse.
interface io_vector_table_slave_if;
  logic        taskValid;
  logic [39:0] address;
  logic        rwCtrl;
  logic [1:0]  widthCtr;
  logic [63:0] writeBus;
  logic        taskReady;
  logic        taskError;
  logic [63:0] readBus;

  modport master (
    output taskValid, address, rwCtrl, widthCtr, writeBus,
    input  taskReady, taskError, readBus
  );

  modport slave (
    input  taskValid, address, rwCtrl, widthCtr, writeBus,
    output taskReady, taskError, readBus
  );
endinterface

// File: rtl/io_vector_table_slave.sv
// On-chip 64-bit SRAM window answering IO_Interface tasks after a fixed latency,
// with range, alignment and write-lock error checking (home of the vector table).
module io_vector_table_slave #(
  parameter logic [39:0] BASE_ADDR   = 40'h0,
  parameter int          DEPTH_WORDS = 256,
  parameter int          LATENCY     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  io_vector_table_slave_if.slave ioInterface,
  input  logic                   wr_lock,
  output logic                   busy
);
  localparam int            AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int            CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [40:0]   SPAN     = 41'(DEPTH_WORDS) << 3;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;

  typedef struct packed {
    logic          write;
    logic          error;
    logic [1:0]    width;
    logic [AW-1:0] word;
    logic [2:0]    lane;
    logic [63:0]   data;
  } taskT;

  stateT         state, stateNext;
  logic [CW-1:0] cnt, cntNext;
  taskT          heldTask, liveTask, curTask;
  logic          enterResp;
  logic [63:0]   mem [DEPTH_WORDS];
  logic [63:0]   readQ, wordRd, widthMask, laneMask, wordWr, readData;

  // Below-base is checked on the raw address, so a wrapped offset never aliases in range.
  function automatic taskT decodeTask(input logic [39:0] addr, input logic rw,
                                      input logic [1:0] width, input logic [63:0] wdata,
                                      input logic lock);
    taskT        t;
    logic [39:0] off;
    logic        misaligned;
    off = addr - BASE_ADDR;
    case (width)
      2'd0: misaligned = 1'b0;
      2'd1: misaligned = addr[0];
      2'd2: misaligned = |addr[1:0];
      2'd3: misaligned = |addr[2:0];
    endcase
    t.write = rw;
    t.width = width;
    t.data  = wdata;
    t.word  = off[AW+2:3];
    t.lane  = off[2:0];
    t.error = (addr < BASE_ADDR) || ({1'b0, off} >= SPAN) || misaligned || (rw && lock);
    return t;
  endfunction

  assign liveTask  = decodeTask(ioInterface.address, ioInterface.rwCtrl, ioInterface.widthCtr,
                                ioInterface.writeBus, wr_lock);
  // With LATENCY=1 the commit edge is the acceptance edge, so the live request is used there.
  assign curTask   = (state == IDLE) ? liveTask : heldTask;
  assign enterResp = (stateNext == RESP) && (state != RESP);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    stateNext             = state;
    cntNext               = cnt;
    busy                  = 1'b1;
    ioInterface.taskReady = 1'b0;
    ioInterface.taskError = 1'b0;
    ioInterface.readBus   = '0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (ioInterface.taskValid) begin
          cntNext   = CNT_LOAD;
          stateNext = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cntNext = cnt - CW'(1);
        if (cnt == CW'(1)) stateNext = RESP;
      end
      RESP: begin
        ioInterface.taskReady = 1'b1;
        ioInterface.taskError = heldTask.error;
        ioInterface.readBus   = readQ;
        stateNext             = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      heldTask <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      if (state == IDLE && ioInterface.taskValid) heldTask <= liveTask;
    end
  end

  always_comb begin
    wordRd = mem[curTask.word];
    case (curTask.width)
      2'd0: widthMask = 64'h0000_0000_0000_00FF;
      2'd1: widthMask = 64'h0000_0000_0000_FFFF;
      2'd2: widthMask = 64'h0000_0000_FFFF_FFFF;
      2'd3: widthMask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    laneMask = widthMask << {curTask.lane, 3'b000};
    wordWr   = (wordRd & ~laneMask) | ((curTask.data & widthMask) << {curTask.lane, 3'b000});
    readData = (curTask.error || curTask.write) ? '0
             : (wordRd >> {curTask.lane, 3'b000}) & widthMask;
  end

  // NOTE: the array and its read register carry no reset so they map onto SRAM;
  // contents survive rst, and readQ is only visible while the FSM is in RESP.
  always_ff @(posedge clk) begin
    if (enterResp) begin
      if (curTask.write && !curTask.error) mem[curTask.word] <= wordWr;
      readQ <= readData;
    end
  end
endmodule

// File: tb/tb_io_vector_table_slave.sv
// Randomized scoreboard bench for io_vector_table_slave against a byte-array memory model.
// The driver pushes expected responses; a negedge monitor pops and compares them.
module tb_io_vector_table_slave;
  localparam int LAT   = 2;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic wrLock = 1'b0;
  logic busy;

  io_vector_table_slave_if ioIf();

  io_vector_table_slave #(
    .BASE_ADDR(40'h0), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .ioInterface(ioIf), .wr_lock(wrLock), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        err;
    logic [63:0] data;
    int          tag;
  } expT;

  expT         sbq[$];
  logic [7:0]  mdl [DEPTH*8];
  int          checks = 0;
  int          errors = 0;
  int          ntask  = 0;
  int          busyLo = 1;
  int          busyHi = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Byte-addressed reference: each task touches 2^w consecutive bytes starting at addr.
  function automatic void model(input logic rw, input logic [1:0] w, input logic [39:0] a,
                                input logic [63:0] d, input logic lock,
                                output logic err, output logic [63:0] rd);
    int size;
    size = 1 << w;
    err  = (a >= 40'(DEPTH*8)) || ((a % 40'(size)) != 0) || (rw && lock);
    rd   = '0;
    if (!err) begin
      for (int i = 0; i < size; i++) begin
        if (rw) mdl[int'(a) + i] = d[8*i +: 8];
        else    rd[8*i +: 8]     = mdl[int'(a) + i];
      end
    end
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      check("busy window", 64'(busy), 64'((cyc >= busyLo) && (cyc <= busyHi)));
      if (ioIf.taskReady) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected taskReady @cycle %0d: got 1 expected 0", cyc);
        end else begin
          expT e;
          e = sbq.pop_front();
          check($sformatf("task%0d ready cycle", e.tag), 64'(cyc), 64'(e.cyc));
          check($sformatf("task%0d taskError", e.tag), 64'(ioIf.taskError), 64'(e.err));
          check($sformatf("task%0d readBus", e.tag), ioIf.readBus, e.data);
        end
      end else begin
        check("idle error/readBus", {63'(ioIf.readBus != 0), ioIf.taskError}, 64'd0);
      end
    end
  end

  // Presents one task in the current cycle and holds it until taskReady; when noisy,
  // the request lines (including taskValid) are scrambled while the task is in flight.
  task automatic issue(input logic rw, input logic [1:0] w, input logic [39:0] a,
                       input logic [63:0] d, input logic lock, input bit gap, input bit noisy);
    expT e;
    int  waited;
    ioIf.taskValid = 1'b1;
    ioIf.rwCtrl    = rw;
    ioIf.widthCtr  = w;
    ioIf.address   = a;
    ioIf.writeBus  = d;
    wrLock         = lock;
    model(rw, w, a, d, lock, e.err, e.data);
    e.cyc = cyc + LAT;
    e.tag = ntask++;
    sbq.push_back(e);
    busyLo = cyc + 1;
    busyHi = cyc + LAT;
    waited = 0;
    do begin
      @(posedge clk); #1;
      waited++;
      if (noisy) begin
        ioIf.address  = {8'($urandom), 32'($urandom)};
        ioIf.writeBus = {$urandom, $urandom};
        ioIf.rwCtrl   = 1'($urandom);
        ioIf.widthCtr = 2'($urandom);
        wrLock        = 1'($urandom);
        if ($urandom_range(0, 3) == 0) ioIf.taskValid = ~ioIf.taskValid;
      end
    end while (!ioIf.taskReady && waited < 10);
    check($sformatf("task%0d taskReady seen", e.tag), 64'(ioIf.taskReady), 64'd1);
    @(posedge clk); #1;
    if (gap) begin
      ioIf.taskValid = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          seen;
    logic        rw;
    logic [1:0]  w;
    logic [39:0] a;
    int          sel;

    ioIf.taskValid = 1'b0;
    ioIf.rwCtrl    = 1'b0;
    ioIf.widthCtr  = 2'd0;
    ioIf.address   = '0;
    ioIf.writeBus  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset taskReady", 64'(ioIf.taskReady), 64'd0);
    check("reset taskError", 64'(ioIf.taskError), 64'd0);
    check("reset readBus", ioIf.readBus, 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < DEPTH; i++)
      issue(1'b1, 2'd3, 40'(i * 8), {$urandom, $urandom}, 1'b0, 1'($urandom), 1'b0);

    issue(1'b1, 2'd3, 40'h40, 64'h1122334455667788, 1'b0, 1'b1, 1'b0);
    issue(1'b0, 2'd3, 40'h40, 64'd0, 1'b0, 1'b1, 1'b0);
    issue(1'b0, 2'd0, 40'h43, 64'd0, 1'b0, 1'b1, 1'b0);
    issue(1'b1, 2'd1, 40'h44, 64'hABCD, 1'b0, 1'b1, 1'b0);
    issue(1'b0, 2'd3, 40'h40, 64'd0, 1'b0, 1'b1, 1'b0);
    issue(1'b0, 2'd2, 40'h42, 64'd0, 1'b0, 1'b1, 1'b0);
    issue(1'b0, 2'd3, 40'h800, 64'd0, 1'b0, 1'b1, 1'b0);
    issue(1'b1, 2'd3, 40'h10, 64'hCAFE_F00D_1234_5678, 1'b1, 1'b1, 1'b0);
    issue(1'b0, 2'd3, 40'h10, 64'd0, 1'b0, 1'b1, 1'b0);
    issue(1'b0, 2'd3, 40'h40, 64'd0, 1'b0, 1'b1, 1'b0);
    issue(1'b1, 2'd2, 40'h7FC, 64'h0BAD_BEEF, 1'b0, 1'b0, 1'b0);
    issue(1'b0, 2'd3, 40'h7F8, 64'd0, 1'b0, 1'b0, 1'b0);
    issue(1'b0, 2'd0, 40'h7FF, 64'd0, 1'b0, 1'b0, 1'b0);
    issue(1'b0, 2'd3, 40'h7FF, 64'd0, 1'b0, 1'b0, 1'b0);
    issue(1'b0, 2'd0, 40'hFF_FFFF_FFF8, 64'd0, 1'b0, 1'b1, 1'b1);
    issue(1'b0, 2'd1, 40'h46, 64'd0, 1'b0, 1'b0, 1'b1);
    issue(1'b0, 2'd1, 40'h44, 64'd0, 1'b0, 1'b1, 1'b1);

    // Reset pulse while a write to 0x80 sits in WAIT.
    ioIf.taskValid = 1'b1;
    ioIf.rwCtrl    = 1'b1;
    ioIf.widthCtr  = 2'd3;
    ioIf.address   = 40'h80;
    ioIf.writeBus  = 64'hDEAD_BEEF_0BAD_F00D;
    wrLock         = 1'b0;
    busyLo         = cyc + 1;
    busyHi         = cyc + LAT;
    @(posedge clk); #1;
    check("busy in WAIT before rst", 64'(busy), 64'd1);
    busyHi = -1;
    rst    = 1'b0;
    #1;
    check("busy after rst", 64'(busy), 64'd0);
    ioIf.taskValid = 1'b0;
    @(posedge clk); #1;
    rst  = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (ioIf.taskReady) seen = 1;
    end
    check("no taskReady after rst", 64'(seen), 64'd0);
    @(posedge clk); #1;
    issue(1'b0, 2'd3, 40'h80, 64'd0, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 300; i++) begin
      rw  = 1'($urandom);
      w   = 2'($urandom);
      sel = $urandom_range(0, 15);
      if (sel == 0)      a = {8'($urandom), 32'($urandom)};
      else if (sel == 1) a = 40'($urandom_range(2048, 2100));
      else begin
        a = 40'($urandom_range(0, 2047));
        if (sel > 3) a = a & ~40'((1 << w) - 1);
      end
      issue(rw, w, a, {$urandom, $urandom}, 1'($urandom_range(0, 3) == 0),
            (i == 299) ? 1'b1 : 1'($urandom), 1'b1);
    end

    ioIf.taskValid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("scoreboard drained", 64'(sbq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/io_vector_table_slave.md
# io_vector_table_slave

Responder (slave) end of the core's IO_Interface memory-bus protocol. It is an on-chip 64-bit-wide SRAM window that serves single read/write tasks from an IO_Interface master, such as the write-back stage's interrupt-vector fetch (64-bit read at `interCode<<3`). It sits behind the `ioBus_select` mux in place of, or beside, the data-cache/MMU path. It gives the interrupt vector table a fixed-latency, error-checked home, and it doubles as a bus-protocol model for verification.

## Interface
Parameters:
- BASE_ADDR, 40'h0: first byte address of the window.
- DEPTH_WORDS, 256: number of 64-bit words; power of 2, ≥2.
- LATENCY, 2: cycles from task acceptance to taskReady; ≥1.

Ports:
- clk  in  1  clock; reset rst, asynchronous, active-low; clock clk.
- rst  in  1  asynchronous active-low reset.
- ioInterface.taskValid  in  1  task request, held by master until taskReady.
- ioInterface.address  in  40  byte address.
- ioInterface.rwCtrl  in  1  0 = read, 1 = write.
- ioInterface.widthCtr  in  2  access size: 0 = 8b, 1 = 16b, 2 = 32b, 3 = 64b.
- ioInterface.writeBus  in  64  write data, right-aligned (bits [8·2^w−1:0] used).
- ioInterface.taskReady  out  1  one-cycle completion pulse.
- ioInterface.taskError  out  1  valid only with taskReady; 1 = task failed.
- ioInterface.readBus  out  64  read data, right-aligned, zero-extended; valid only with taskReady.
- wr_lock  in  1  1 = all writes fail with error (vector-table protection).
- busy  out  1  1 while a task is accepted and not yet answered.

## Operation
- FSM states:
  - IDLE: busy=0. If taskValid=1, latch address, rwCtrl, widthCtr, writeBus and wr_lock. Compute error, load the counter with LATENCY−1, then go to WAIT, or go directly to RESP if LATENCY=1.
  - WAIT: decrement the counter; go to RESP when it reaches 0.
  - RESP: taskReady=1 for exactly one cycle, drive readBus/taskError, then return to IDLE.
- Error if any of the following holds; an errored task never modifies memory and returns readBus=0:
  - address < BASE_ADDR or address ≥ BASE_ADDR + DEPTH_WORDS·8;
  - address misaligned, i.e. address mod 2^widthCtr ≠ 0;
  - write with latched wr_lock=1.
- Offset arithmetic:
  - off = address − BASE_ADDR, computed in 40 bits with no wrap; the below-base check happens first.
  - word = off[log2(DEPTH)+2:3].
  - lane = off[2:0].
- Little-endian lanes:
  - Read returns mem[word] >> (8·lane), masked to the access width.
  - Write replaces only bytes lane .. lane+2^w−1 of mem[word]; all other bytes are unchanged.
- The write commits on the clock edge that enters RESP. The read samples memory on that same edge, so it reflects any earlier committed write.
- Inputs are latched at acceptance. Changes to taskValid, address or wr_lock during WAIT/RESP do not affect the task in flight. Dropping taskValid mid-task does not abort the task.
- Memory contents are not initialised by rst and persist across rst.

## Timing
- Reset values:
  - taskReady=0, taskError=0, readBus=0, busy=0.
  - FSM in IDLE, counter=0.
- taskValid sampled high in IDLE in cycle k → busy high in cycles k+1 .. k+LATENCY → taskReady high in cycle k+LATENCY only.
- Latency is identical for errored and good tasks.
- The RESP→IDLE edge does not accept a task, even if taskValid=1. The earliest next acceptance is cycle k+LATENCY+1, so there is no double-accept of a master that drops taskValid on the same edge it samples taskReady.
- If taskValid is still high in IDLE after a response, it is treated as a new task. It is re-executed with fresh latching.
- rst asserted mid-task: return to IDLE immediately, no taskReady is issued, and an uncommitted write is discarded.
- Outside the RESP cycle, readBus and taskError are driven to 0.

## Test plan
All scenarios use BASE_ADDR=0, DEPTH_WORDS=256, LATENCY=2.
- 64b write 0x1122334455667788 to 0x40, then 64b read of 0x40:
  - each taskReady arrives exactly 2 cycles after acceptance, error=0;
  - the read returns 0x1122334455667788.
- After that write, byte read at 0x43 returns 0x55. 16b write of 0xABCD at 0x44, then 64b read of 0x40, returns 0x1122ABCD55667788.
- Error cases, each with taskReady at +2, taskError=1 and readBus=0, and memory verified unchanged by read-back:
  - 32b read at 0x42 (misaligned);
  - 64b read at 0x800 (out of range);
  - 64b write at 0x10 with wr_lock=1.
- Master protocol: the master drops taskValid on the taskReady edge, then reasserts it in the next cycle. Exactly one taskReady per task; the second acceptance occurs no earlier than the cycle after RESP.
- rst pulsed low during WAIT of a write to 0x80:
  - no taskReady;
  - busy=0 immediately;
  - a subsequent read of 0x80 returns the pre-reset value.
